// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes format from the opcode, assembles and
// sign-extends the immediate, and registers it behind a valid/ready skid stage.
module imm_gen_pipe #(
   parameter int XLEN  = 64,
   parameter int FMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [FMT_W-1:0] out_fmt,
   output logic [31:0]      out_instr
);

   localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
   localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
   localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
   localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
   localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
   localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);

   function automatic logic [FMT_W-1:0] decodeFmt(input logic [6:0] opcode);
      case (opcode)
         7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: decodeFmt = FMT_I;
         7'b0100011:                                     decodeFmt = FMT_S;
         7'b1100011:                                     decodeFmt = FMT_B;
         7'b0110111, 7'b0010111:                         decodeFmt = FMT_U;
         7'b1101111:                                     decodeFmt = FMT_J;
         default:                                        decodeFmt = FMT_NONE;
      endcase
   endfunction

   function automatic logic signed [XLEN-1:0] signExtend(input logic signed [31:0] imm32);
      signExtend = XLEN'(imm32);
   endfunction

   // Every format is first widened to a signed 32-bit value, then to XLEN.
   function automatic logic signed [XLEN-1:0] assembleImm(input logic [31:0]      ins,
                                                          input logic [FMT_W-1:0] fmt);
      logic signed [31:0] imm32;
      case (fmt)
         FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
         FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         FMT_U:   imm32 = {ins[31:12], 12'b0};
         FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      assembleImm = signExtend(imm32);
   endfunction

   // Stage 0: combinational decode of the incoming word
   logic [FMT_W-1:0] fmt_p0;
   logic [XLEN-1:0]  imm_p0;

   assign fmt_p0 = decodeFmt(in_instr[6:0]);
   assign imm_p0 = assembleImm(in_instr, fmt_p0);

   // Stage 1: main output register plus one-entry skid
   logic             mainVld_p1;
   logic [XLEN-1:0]  mainImm_p1;
   logic [FMT_W-1:0] mainFmt_p1;
   logic [31:0]      mainInstr_p1;
   logic             skidVld_p1;
   logic [XLEN-1:0]  skidImm_p1;
   logic [FMT_W-1:0] skidFmt_p1;
   logic [31:0]      skidInstr_p1;

   logic accept;
   logic consume;
   logic loadMain;
   logic loadSkid;

   assign accept   = in_valid && in_ready;
   assign consume  = mainVld_p1 && out_ready;
   assign loadMain = accept && (!mainVld_p1 || consume);
   assign loadSkid = accept && mainVld_p1 && !consume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainVld_p1   <= 1'b0;
         skidVld_p1   <= 1'b0;
         mainImm_p1   <= '0;
         mainFmt_p1   <= '0;
         mainInstr_p1 <= '0;
      end else begin
         if (consume && skidVld_p1) begin
            mainImm_p1   <= skidImm_p1;
            mainFmt_p1   <= skidFmt_p1;
            mainInstr_p1 <= skidInstr_p1;
            mainVld_p1   <= 1'b1;
            skidVld_p1   <= 1'b0;
         end else if (loadMain) begin
            mainImm_p1   <= imm_p0;
            mainFmt_p1   <= fmt_p0;
            mainInstr_p1 <= in_instr;
            mainVld_p1   <= 1'b1;
         end else if (consume) begin
            mainVld_p1   <= 1'b0;
         end
         if (loadSkid) begin
            skidVld_p1 <= 1'b1;
         end
      end
   end

   // Skid payload is only ever read while its valid bit is set.
   always_ff @(posedge clk) begin
      if (loadSkid) begin
         skidImm_p1   <= imm_p0;
         skidFmt_p1   <= fmt_p0;
         skidInstr_p1 <= in_instr;
      end
   end

   assign in_ready  = !skidVld_p1;
   assign out_valid = mainVld_p1;
   assign out_imm   = mainImm_p1;
   assign out_fmt   = mainFmt_p1;
   assign out_instr = mainInstr_p1;

endmodule
